mmio_timer_bank: RTL and testbench

Parametrised memory-mapped peripheral unit for the MEM stage. It provides NUM_TIMERS independent reload timers, each with a prescaler, one-shot mode and a maskable interrupt flag, plus LED, 7-segment and Systick registers. Decoding is single-cycle. The MEM read mux selects rd_data when hit=1 and falls back to RAM/ROM otherwise.

---
 rtl/mmio_timer_bank_pkg.sv | 41 ++++
 rtl/mmio_timer_bank_if.sv | 11 +
 rtl/mmio_timer_bank_timer_channel.sv | 75 +++++++
 rtl/mmio_timer_bank.sv | 110 +++++++++++
 tb/tb_mmio_timer_bank.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_timer_bank_pkg.sv
// Shared constants for the MEM-stage peripheral window: register offsets,
// channel stride, TCON bit positions and reset values.
package mmio_pkg;

    localparam logic [31:0] CHAN_STRIDE = 32'd16;
    localparam logic [31:0] MISC_OFFSET = 32'h100;

    // Per-channel register offsets within one 16-byte stride
    localparam logic [3:0] OFF_TH    = 4'h0;
    localparam logic [3:0] OFF_TL    = 4'h4;
    localparam logic [3:0] OFF_TCON  = 4'h8;
    localparam logic [3:0] OFF_PRESC = 4'hC;

    // Misc register offsets relative to MISC_OFFSET
    localparam logic [3:0] OFF_LEDS    = 4'h0;
    localparam logic [3:0] OFF_DIGIT   = 4'h4;
    localparam logic [3:0] OFF_SYSTICK = 4'h8;

    localparam int TCON_EN      = 0;
    localparam int TCON_IRQ_EN  = 1;
    localparam int TCON_FLAG    = 2;
    localparam int TCON_ONESHOT = 3;

    localparam logic [7:0] DIGIT_RESET = 8'hFF;

    typedef enum logic [1:0] {
        REG_TH    = 2'd0,
        REG_TL    = 2'd1,
        REG_TCON  = 2'd2,
        REG_PRESC = 2'd3
    } chan_reg_e;

    // Field order matches the TCON bit indices so the struct reads back directly
    typedef struct packed {
        logic oneshot;
        logic flag;
        logic irq_en;
        logic en;
    } tcon_t;

endpackage

// File: rtl/mmio_timer_bank_if.sv
// Load/store bus between the MEM stage and the timer/LED peripheral block.
interface mmio_timer_bank_if;
    logic [31:0] addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        hit;

    modport master (output addr, wr_en, wr_data, input rd_data, hit);
    modport slave  (input addr, wr_en, wr_data, output rd_data, hit);
endinterface

// File: rtl/mmio_timer_bank_timer_channel.sv
// One reload timer: TH/TL/PRESC/TCON plus prescale counter; overflow reloads
// TL from TH, sets FLAG and optionally stops the channel (one-shot).
module timer_channel
    import mmio_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        wr_data,
    input  logic               we_th,
    input  logic               we_tl,
    input  logic               we_tcon,
    input  logic               we_presc,
    output logic [TIMER_W-1:0] th,
    output logic [TIMER_W-1:0] tl,
    output logic [TIMER_W-1:0] presc,
    output tcon_t              tcon,
    output logic               irq_req
);

    logic [TIMER_W-1:0] pc;
    logic [TIMER_W-1:0] wdata;
    logic               tick;
    logic               overflow;

    assign wdata    = wr_data[TIMER_W-1:0];
    assign tick     = tcon.en && (pc == presc);
    // A TL write in the tick cycle replaces the count, so no overflow is seen
    assign overflow = tick && (&tl) && !we_tl;
    assign irq_req  = tcon.flag && tcon.irq_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            th    <= '0;
            tl    <= '0;
            presc <= '0;
            tcon  <= '0;
            pc    <= '0;
        end else begin
            if (we_th)
                th <= wdata;
            if (we_presc)
                presc <= wdata;

            if (!tcon.en || we_presc || tick)
                pc <= '0;
            else
                pc <= pc + TIMER_W'(1);

            // Reload uses the TH value held before any same-cycle TH write
            if (we_tl)
                tl <= wdata;
            else if (overflow)
                tl <= th;
            else if (tick)
                tl <= tl + TIMER_W'(1);

            if (we_tcon) begin
                tcon.en      <= wr_data[TCON_EN];
                tcon.irq_en  <= wr_data[TCON_IRQ_EN];
                tcon.oneshot <= wr_data[TCON_ONESHOT];
            end else if (overflow && tcon.oneshot) begin
                tcon.en <= 1'b0;
            end

            // Set beats write-1-to-clear
            if (overflow)
                tcon.flag <= 1'b1;
            else if (we_tcon && wr_data[TCON_FLAG])
                tcon.flag <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_timer_bank.sv
// MEM-stage peripheral window: NUM_TIMERS reload timers plus LED, 7-segment
// and Systick registers, with single-cycle decode and a combinational read mux.
module mmio_timer_bank
    import mmio_pkg::*;
#(
    parameter int          NUM_TIMERS = 2,
    parameter int          TIMER_W    = 32,
    parameter int          LED_W      = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h40000000
) (
    input  logic              clk,
    input  logic              reset,
    mmio_timer_bank_if.slave  bus,
    input  logic [31:0]       systick,
    output logic              irq,
    output logic [LED_W-1:0]  leds,
    output logic [7:0]        digit,
    output logic [3:0]        digit_en
);

    logic [31:0] offset;
    logic        aligned;
    logic        chan_hit;
    logic        misc_hit;
    logic [2:0]  chan_sel;
    chan_reg_e   chan_reg;
    logic [3:0]  misc_sel;

    logic [TIMER_W-1:0]    th_v    [NUM_TIMERS];
    logic [TIMER_W-1:0]    tl_v    [NUM_TIMERS];
    logic [TIMER_W-1:0]    presc_v [NUM_TIMERS];
    tcon_t                 tcon_v  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] irq_req;

    // Addresses below the base wrap to huge offsets and fall out of both ranges
    assign offset   = bus.addr - BASE_ADDR;
    assign aligned  = (bus.addr[1:0] == 2'b00);
    assign chan_hit = aligned && (offset < CHAN_STRIDE * 32'(NUM_TIMERS));
    assign chan_sel = offset[6:4];
    assign chan_reg = chan_reg_e'(offset[3:2]);
    assign misc_sel = offset[3:0];
    assign misc_hit = aligned && (offset[31:4] == MISC_OFFSET[31:4])
                      && (misc_sel != 4'hC);

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
        logic sel;
        assign sel = bus.wr_en && chan_hit && (chan_sel == 3'(i));

        timer_channel #(.TIMER_W(TIMER_W)) u_chan (
            .clk      (clk),
            .reset    (reset),
            .wr_data  (bus.wr_data),
            .we_th    (sel && (chan_reg == REG_TH)),
            .we_tl    (sel && (chan_reg == REG_TL)),
            .we_tcon  (sel && (chan_reg == REG_TCON)),
            .we_presc (sel && (chan_reg == REG_PRESC)),
            .th       (th_v[i]),
            .tl       (tl_v[i]),
            .presc    (presc_v[i]),
            .tcon     (tcon_v[i]),
            .irq_req  (irq_req[i])
        );
    end

    assign irq = |irq_req;

    always_comb begin
        bus.rd_data = '0;
        bus.hit     = 1'b0;
        if (chan_hit) begin
            bus.hit = 1'b1;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (chan_sel == 3'(i)) begin
                    case (chan_reg)
                        REG_TH:    bus.rd_data = 32'(th_v[i]);
                        REG_TL:    bus.rd_data = 32'(tl_v[i]);
                        REG_TCON:  bus.rd_data = 32'(tcon_v[i]);
                        REG_PRESC: bus.rd_data = 32'(presc_v[i]);
                        default:   bus.rd_data = '0;
                    endcase
                end
            end
        end else if (misc_hit) begin
            bus.hit = 1'b1;
            case (misc_sel)
                OFF_LEDS:    bus.rd_data = 32'(leds);
                OFF_DIGIT:   bus.rd_data = {20'd0, digit_en, digit};
                OFF_SYSTICK: bus.rd_data = systick;
                default: begin
                    bus.rd_data = '0;
                    bus.hit     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds     <= '0;
            digit    <= DIGIT_RESET;
            digit_en <= '0;
        end else if (bus.wr_en && misc_hit) begin
            if (misc_sel == OFF_LEDS)
                leds <= bus.wr_data[LED_W-1:0];
            if (misc_sel == OFF_DIGIT)
                {digit_en, digit} <= bus.wr_data[11:0];
        end
    end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Randomised and directed bench for mmio_timer_bank: a cycle-level reference
// model predicts every output; a negedge monitor compares against a queue.
module tb_mmio_timer_bank;

    localparam int          N    = 2;
    localparam logic [31:0] BASE = 32'h40000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] systick;
    logic        irq;
    logic [7:0]  leds;
    logic [7:0]  digit;
    logic [3:0]  digit_en;

    always #5 clk = ~clk;

    mmio_timer_bank_if bus ();

    mmio_timer_bank #(
        .NUM_TIMERS (N),
        .TIMER_W    (32),
        .LED_W      (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .systick  (systick),
        .irq      (irq),
        .leds     (leds),
        .digit    (digit),
        .digit_en (digit_en)
    );

    // Reference model state
    logic [31:0] m_th [N], m_tl [N], m_presc [N], m_pc [N];
    bit          m_en [N], m_ie [N], m_flag [N], m_os [N];
    logic [7:0]  m_leds, m_digit;
    logic [3:0]  m_den;

    typedef struct packed {
        logic [31:0] rd;
        logic        hit;
        logic        irq;
        logic [7:0]  leds;
        logic [7:0]  digit;
        logic [3:0]  den;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    vectors     = 0;
    int    miscompares = 0;

    // kind: 0 unmapped, 1 channel register, 2 LEDS, 3 DIGIT, 4 SYSTICK
    function automatic void decode(input logic [31:0] a, output int kind,
                                   output int ch, output int r);
        logic [31:0] off;
        kind = 0; ch = 0; r = 0;
        off  = a - BASE;
        if (a[1:0] == 2'b00 && a >= BASE) begin
            if (off < 32'(16 * N)) begin
                kind = 1;
                ch   = int'(off / 16);
                r    = int'((off % 16) / 4);
            end else if (off == 32'h100) kind = 2;
            else if (off == 32'h104) kind = 3;
            else if (off == 32'h108) kind = 4;
        end
    endfunction

    function automatic logic [32:0] model_read(input logic [31:0] a);
        int kind, ch, r;
        decode(a, kind, ch, r);
        case (kind)
            1: case (r)
                   0: return {1'b1, m_th[ch]};
                   1: return {1'b1, m_tl[ch]};
                   2: return {1'b1, 28'd0, m_os[ch], m_flag[ch], m_ie[ch], m_en[ch]};
                   default: return {1'b1, m_presc[ch]};
               endcase
            2: return {1'b1, 24'd0, m_leds};
            3: return {1'b1, 20'd0, m_den, m_digit};
            4: return {1'b1, systick};
            default: return 33'd0;
        endcase
    endfunction

    function automatic logic model_irq();
        logic any = 1'b0;
        for (int c = 0; c < N; c++) any |= (m_flag[c] && m_ie[c]);
        return any;
    endfunction

    // Advance the model across one clock edge given that cycle's inputs
    function automatic void model_step(input logic [31:0] a, input logic we,
                                       input logic [31:0] wd, input logic rst);
        int kind, ch, r;
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                m_th[c] = 0; m_tl[c] = 0; m_presc[c] = 0; m_pc[c] = 0;
                m_en[c] = 0; m_ie[c] = 0; m_flag[c] = 0; m_os[c] = 0;
            end
            m_leds = 0; m_digit = 8'hFF; m_den = 0;
            return;
        end
        decode(a, kind, ch, r);
        for (int c = 0; c < N; c++) begin
            bit mine, tick, ovf;
            logic [31:0] n_tl, n_pc;
            bit n_en, n_flag;
            mine   = we && kind == 1 && ch == c;
            tick   = m_en[c] && (m_pc[c] == m_presc[c]);
            ovf    = 0;
            n_tl   = m_tl[c];
            n_en   = m_en[c];
            n_flag = m_flag[c];
            n_pc   = (!m_en[c] || tick) ? 32'd0 : m_pc[c] + 1;
            if (mine && r == 3) n_pc = 0;
            if (mine && r == 1) n_tl = wd;
            else if (tick) begin
                if (m_tl[c] == 32'hFFFFFFFF) begin
                    ovf  = 1;
                    n_tl = m_th[c];
                    if (m_os[c]) n_en = 0;
                end else n_tl = m_tl[c] + 1;
            end
            if (mine && r == 2) begin
                n_en    = wd[0];
                m_ie[c] = wd[1];
                m_os[c] = wd[3];
                if (wd[2]) n_flag = 0;
            end
            if (ovf) n_flag = 1;
            if (mine && r == 0) m_th[c] = wd;
            if (mine && r == 3) m_presc[c] = wd;
            m_tl[c] = n_tl; m_pc[c] = n_pc; m_en[c] = n_en; m_flag[c] = n_flag;
        end
        if (we && kind == 2) m_leds = wd[7:0];
        if (we && kind == 3) {m_den, m_digit} = wd[11:0];
    endfunction

    // One bus cycle: drive, queue the expected outputs, step the model at the edge
    task automatic cycle(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic rst, input bit ovr, input logic [31:0] ovr_val,
                         input string tag);
        exp_t        e;
        logic [32:0] mr;
        bus.addr    = a;
        bus.wr_en   = we;
        bus.wr_data = wd;
        reset       = rst;
        mr     = model_read(a);
        e.rd   = ovr ? ovr_val : mr[31:0];
        e.hit  = mr[32];
        e.irq  = model_irq();
        e.leds = m_leds;
        e.digit = m_digit;
        e.den  = m_den;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        model_step(a, we, wd, rst);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(a, 1'b1, d, 1'b0, 1'b0, 32'd0, "write");
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(a, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, "read");
    endtask

    task automatic chk(input logic [31:0] a, input logic [31:0] v, input string tag);
        cycle(a, 1'b0, 32'd0, 1'b0, 1'b1, v, tag);
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s.%s actual=0x%08h required=0x%08h at %0t",
                     tag, field, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            cmp(t, "rd_data",  bus.rd_data,     e.rd);
            cmp(t, "hit",      32'(bus.hit),    32'(e.hit));
            cmp(t, "irq",      32'(irq),        32'(e.irq));
            cmp(t, "leds",     32'(leds),       32'(e.leds));
            cmp(t, "digit",    32'(digit),      32'(e.digit));
            cmp(t, "digit_en", 32'(digit_en),   32'(e.den));
        end
    end

    initial begin
        bus.addr    = 0;
        bus.wr_en   = 0;
        bus.wr_data = 0;
        reset       = 1;
        systick     = 32'h1234;
        model_step(0, 0, 0, 1);
        @(posedge clk);
        #1;

        // Reset defaults
        cycle(BASE + 32'h104, 0, 0, 1, 1, 32'h0FF, "rst_digit");
        cycle(BASE + 32'h008, 0, 0, 1, 1, 32'h0, "rst_tcon0");
        chk(BASE + 32'h018, 32'h0, "rst_tcon1");
        chk(BASE + 32'h108, 32'h1234, "systick");

        // Auto-reload on channel 0
        wr(BASE + 32'h0, 32'hFFFFFFFD);
        wr(BASE + 32'h4, 32'hFFFFFFFD);
        wr(BASE + 32'h8, 32'h3);
        chk(BASE + 32'h4, 32'hFFFFFFFD, "ar_tl0");
        chk(BASE + 32'h4, 32'hFFFFFFFE, "ar_tl1");
        chk(BASE + 32'h4, 32'hFFFFFFFF, "ar_tl2");
        chk(BASE + 32'h8, 32'h7, "ar_flag");
        chk(BASE + 32'h4, 32'hFFFFFFFE, "ar_reload");
        wr(BASE + 32'h8, 32'h7);               // W1C in the overflow cycle
        chk(BASE + 32'h8, 32'h7, "w1c_vs_ovf");
        wr(BASE + 32'h8, 32'h7);               // plain W1C
        chk(BASE + 32'h8, 32'h3, "w1c_clear");
        wr(BASE + 32'h8, 32'h0);

        // Prescaler + one-shot on channel 1
        wr(BASE + 32'h1C, 32'd3);
        wr(BASE + 32'h14, 32'hFFFFFFFE);
        wr(BASE + 32'h18, 32'h9);
        for (int i = 0; i < 4; i++) chk(BASE + 32'h14, 32'hFFFFFFFE, "ps_tl_a");
        for (int i = 0; i < 4; i++) chk(BASE + 32'h14, 32'hFFFFFFFF, "ps_tl_b");
        chk(BASE + 32'h14, 32'h0, "os_reload");
        chk(BASE + 32'h18, 32'hC, "os_tcon");
        for (int i = 0; i < 3; i++) chk(BASE + 32'h14, 32'h0, "os_hold");

        // TL write colliding with a tick on channel 0
        wr(BASE + 32'h8, 32'h1);
        wr(BASE + 32'h4, 32'h10);
        chk(BASE + 32'h4, 32'h10, "tl_wr_wins");
        wr(BASE + 32'h8, 32'h0);
        chk(BASE + 32'h4, 32'h12, "ch0_stopped");

        // Channel 1 traffic must not disturb channel 0
        wr(BASE + 32'h1C, 32'h0);
        wr(BASE + 32'h10, 32'h1234);
        wr(BASE + 32'h14, 32'hFFFFFFFF);
        wr(BASE + 32'h18, 32'h7);
        chk(BASE + 32'h4, 32'h12, "ch0_iso_tl");
        chk(BASE + 32'h14, 32'h1234, "ch1_reload");
        chk(BASE + 32'h0, 32'hFFFFFFFD, "ch0_iso_th");
        wr(BASE + 32'h18, 32'h4);
        rd(BASE + 32'h18);

        // Decode edges and misc registers
        wr(BASE + 32'h2, 32'hFFFFFFFF);
        chk(BASE + 32'h2, 32'h0, "unaligned");
        chk(BASE + 32'h0, 32'hFFFFFFFD, "unaligned_ignored");
        chk(BASE + 32'h20, 32'h0, "past_channels");
        wr(BASE + 32'h104, 32'hABC);
        chk(BASE + 32'h104, 32'hABC, "digit");
        wr(BASE + 32'h100, 32'h1A5);
        chk(BASE + 32'h100, 32'hA5, "leds_trunc");
        wr(BASE + 32'h108, 32'hDEAD);
        chk(BASE + 32'h108, 32'h1234, "systick_ro");

        // Reset mid-count
        wr(BASE + 32'h4, 32'h50);
        wr(BASE + 32'h8, 32'h3);
        for (int i = 0; i < 5; i++) rd(BASE + 32'h4);
        cycle(BASE + 32'h4, 0, 0, 1, 1, 32'h55, "pre_reset");
        chk(BASE + 32'h4, 32'h0, "mid_reset_tl");
        chk(BASE + 32'h8, 32'h0, "mid_reset_tcon");
        chk(BASE + 32'h4, 32'h0, "mid_reset_hold");

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            int          sel;
            logic [31:0] a, d;
            logic        we, rst;
            sel = $urandom_range(0, 15);
            if (sel <= 7 || sel >= 14)
                a = BASE + 32'($urandom_range(0, 2)) * 16 + 32'($urandom_range(0, 3)) * 4;
            else if (sel == 8)  a = BASE + 32'h100;
            else if (sel == 9)  a = BASE + 32'h104;
            else if (sel == 10) a = BASE + 32'h108;
            else if (sel == 11) a = BASE + 32'($urandom_range(0, 1)) * 16 + 32'($urandom_range(1, 3));
            else if (sel == 12) a = BASE - 4;
            else                a = BASE + 32'h10C;
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
                2:       d = 32'($urandom_range(0, 15));
                default: d = 32'($urandom_range(0, 3));
            endcase
            we      = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            systick = $urandom;
            cycle(a, we, d, rst, 1'b0, 32'd0, "random");
        end

        bus.wr_en = 0;
        reset     = 0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
